// File: rtl/vec_wb_assembler.sv
// Vector write-back assembler: packs result beats into one register-group write for vec_regfile.
// Optional macro VEC_WB_BACK_TO_BACK_EN lets a new command be accepted during WRITE (no IDLE bubble).
module vec_wb_assembler #(
  parameter int VLEN       = 512,
  parameter int MAX_VLEN   = 4096,
  parameter int BEAT_WIDTH = 512,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [3:0]            cmd_lmul,
  input  logic                  beat_valid,
  output logic                  beat_ready,
  input  logic [BEAT_WIDTH-1:0] beat_data,
  output logic [MAX_VLEN-1:0]   wdata,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  cmd_err
);

  // state   | meaning
  // IDLE    | waiting for a write-back command
  // COLLECT | accepting result beats into the pack buffer
  // WRITE   | one-cycle write pulse to vec_regfile

  localparam int BEATS_PER_REG = VLEN / BEAT_WIDTH;
  localparam int CNT_W         = $clog2(8 * VLEN / BEAT_WIDTH) + 1;
  localparam int EXT_W         = ADDR_WIDTH + 4;
  localparam int NUM_REGS      = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        total_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [MAX_VLEN-1:0]     buf_q, buf_d;

  logic                    load_cmd;
  logic                    err_d;
  logic                    last_beat;
  logic                    beat_fire;

  logic [EXT_W-1:0]        addr_ext, lmul_ext;
  logic                    lmul_ok, aligned, fits, cmd_legal;

  // lmul is a power of two whenever lmul_ok holds, so the mask test is an exact modulo
  assign addr_ext  = EXT_W'(cmd_addr);
  assign lmul_ext  = EXT_W'(cmd_lmul);
  assign lmul_ok   = (cmd_lmul == 4'd1) || (cmd_lmul == 4'd2) ||
                     (cmd_lmul == 4'd4) || (cmd_lmul == 4'd8);
  assign aligned   = (addr_ext & (lmul_ext - EXT_W'(1))) == '0;
  assign fits      = (addr_ext + lmul_ext) <= EXT_W'(NUM_REGS);
  assign cmd_legal = lmul_ok && aligned && fits;

  assign busy      = (state_q != IDLE);
  assign beat_fire = beat_valid && beat_ready;

  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    beat_ready = 1'b0;
    load_cmd   = 1'b0;
    err_d      = 1'b0;
    last_beat  = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_legal) begin
            load_cmd = 1'b1;
            state_d  = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        beat_ready = 1'b1;
        if (beat_valid && (cnt_q == total_q - CNT_W'(1))) begin
          last_beat = 1'b1;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
`ifdef VEC_WB_BACK_TO_BACK_EN
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_legal) begin
            load_cmd = 1'b1;
            state_d  = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Merged view of the buffer including the beat being accepted this cycle,
  // so the final beat lands in wdata on the same edge it is accepted.
  always_comb begin
    buf_d = buf_q;
    if (beat_fire) begin
      buf_d[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] = beat_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      total_q <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      wdata   <= '0;
      waddr   <= '0;
      wr_en   <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en   <= last_beat;
      cmd_err <= err_d;
      if (load_cmd) begin
        addr_q  <= cmd_addr;
        total_q <= CNT_W'(cmd_lmul) * CNT_W'(BEATS_PER_REG);
        cnt_q   <= '0;
        buf_q   <= '0;
      end else if (beat_fire) begin
        buf_q <= buf_d;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // wdata is captured before any back-to-back clear of buf_q can affect it
      if (last_beat) begin
        wdata <= buf_d;
        waddr <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_vec_wb_assembler.sv
// Scoreboard bench for vec_wb_assembler: directed commands/beats, monitor checks writes and errors.
module tb_vec_wb_assembler;
  localparam int VLEN = 512;
  localparam int MAX_VLEN = 4096;
  localparam int BW = 512;
  localparam int AW = 5;
`ifdef VEC_WB_BACK_TO_BACK_EN
  localparam int EXP_GAP = 2;
`else
  localparam int EXP_GAP = 3;
`endif

  logic clk = 1'b0;
  logic reset;
  logic cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [3:0] cmd_lmul;
  logic beat_valid, beat_ready;
  logic [BW-1:0] beat_data;
  logic [MAX_VLEN-1:0] wdata;
  logic [AW-1:0] waddr;
  logic wr_en, busy, cmd_err;

  vec_wb_assembler #(.VLEN(VLEN), .MAX_VLEN(MAX_VLEN), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_lmul(cmd_lmul),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data),
    .wdata(wdata), .waddr(waddr), .wr_en(wr_en), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0]       addr;
    logic [MAX_VLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  bit  err_q[$];
  int  wr_log[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or an error pulse
  initial begin
    wr_t e;
    int bad;
    forever begin
      @(negedge clk);
      if (!reset && (wr_en || cmd_err)) begin
        chk("wr_en_err_exclusive", 64'(wr_en & cmd_err), 64'd0);
        if (wr_en) begin
          wr_log.push_back(cyc);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: waddr %0d with empty scoreboard", waddr);
          end else begin
            e = exp_q.pop_front();
            chk("waddr", 64'(waddr), 64'(e.addr));
            bad = -1;
            for (int s = 0; s < MAX_VLEN / BW; s++)
              if (bad < 0 && wdata[s*BW +: BW] !== e.data[s*BW +: BW]) bad = s;
            if (bad >= 0) begin
              errors++;
              $display("FAIL wdata slot %0d: got %h expected %h", bad,
                       wdata[bad*BW +: BW], e.data[bad*BW +: BW]);
            end
          end
        end
        if (cmd_err) begin
          checks++;
          if (err_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_cmd_err: got 1 expected 0");
          end else begin
            void'(err_q.pop_front());
          end
        end
      end
    end
  end

  task automatic send_cmd(input logic [AW-1:0] a, input logic [3:0] l, output int hs);
    int n = 0;
    @(negedge clk);
    cmd_addr = a; cmd_lmul = l; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL cmd_timeout: cmd_ready got 0 expected 1 (addr %0d)", a);
    end
    @(posedge clk);
    #1;
    hs = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [BW-1:0] d, output int hs);
    int n = 0;
    @(negedge clk);
    beat_data = d; beat_valid = 1'b1;
    while (!beat_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL beat_timeout: beat_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    hs = cyc;
    beat_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(n >= 300), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t e;
    int hs, hs_a, hs_b, hs_last;
    logic [AW-1:0] ia [4];
    logic [3:0]    il [4];
    ia = '{5'd3, 5'd28, 5'd0, 5'd0};
    il = '{4'd2, 4'd8, 4'd3, 4'd0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_lmul = '0;
    beat_valid = 1'b0; beat_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_beat_ready", 64'(beat_ready), 64'd0);
    chk("rst_cmd_err", 64'(cmd_err), 64'd0);
    chk("rst_wdata_zero", 64'(wdata == '0), 64'd1);
    chk("rst_waddr", 64'(waddr), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

    // LMUL=1 with latency check
    wr_log.delete();
    e.addr = 5'd5; e.data = '0; e.data[31:0] = 32'hDEADBEEF;
    exp_q.push_back(e);
    send_cmd(5'd5, 4'd1, hs);
    send_beat(BW'(32'hDEADBEEF), hs_last);
    wait_idle();
    chk("lmul1_write_count", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() == 1) chk("lmul1_latency", 64'(wr_log[0]), 64'(hs_last));

    // LMUL=8 with a stall cycle between beats
    e.addr = 5'd16; e.data = '0;
    for (int k = 0; k < 8; k++) e.data[k*BW +: BW] = BW'(k + 1);
    exp_q.push_back(e);
    send_cmd(5'd16, 4'd8, hs);
    for (int k = 0; k < 8; k++) begin
      send_beat(BW'(k + 1), hs);
      if (k < 7) begin
        @(negedge clk);
        chk("stall_busy", 64'(busy), 64'd1);
      end
    end
    wait_idle();

    // Legal boundary: group ends exactly at the last register
    e.addr = 5'd30; e.data = '0;
    e.data[0 +: BW] = BW'(32'h1E0); e.data[BW +: BW] = BW'(32'h1E1);
    exp_q.push_back(e);
    send_cmd(5'd30, 4'd2, hs);
    send_beat(BW'(32'h1E0), hs);
    send_beat(BW'(32'h1E1), hs);
    wait_idle();

    // Illegal commands, with a beat being offered that must not be taken
    for (int i = 0; i < 4; i++) begin
      err_q.push_back(1'b1);
      beat_data = BW'(32'hBAD0 + i);
      beat_valid = 1'b1;
      send_cmd(ia[i], il[i], hs);
      @(negedge clk);
      chk("illegal_beat_ready", 64'(beat_ready), 64'd0);
      chk("illegal_busy", 64'(busy), 64'd0);
      beat_valid = 1'b0;
    end
    wait_idle();

    // Back-pressure: second command held during COLLECT of the first
    wr_log.delete();
    e.addr = 5'd2; e.data = '0;
    e.data[0 +: BW] = BW'(32'hA0); e.data[BW +: BW] = BW'(32'hA1);
    exp_q.push_back(e);
    e.addr = 5'd4; e.data = '0;
    e.data[0 +: BW] = BW'(32'hB0); e.data[BW +: BW] = BW'(32'hB1);
    exp_q.push_back(e);
    fork
      begin
        send_cmd(5'd2, 4'd2, hs_a);
        send_cmd(5'd4, 4'd2, hs_b);
      end
      begin
        send_beat(BW'(32'hA0), hs);
        send_beat(BW'(32'hA1), hs);
        send_beat(BW'(32'hB0), hs);
        send_beat(BW'(32'hB1), hs);
      end
    join
    wait_idle();
    chk("bp_write_count", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() >= 1) chk("bp_second_cmd_after_write", 64'(hs_b > wr_log[0]), 64'd1);

    // Reset in the middle of COLLECT discards the group
    wr_log.delete();
    send_cmd(5'd8, 4'd4, hs);
    send_beat(BW'(32'h55), hs);
    send_beat(BW'(32'h66), hs);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_wr_en", 64'(wr_en), 64'd0);
    chk("midrst_wdata_zero", 64'(wdata == '0), 64'd1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_write", 64'(wr_log.size()), 64'd0);
    e.addr = 5'd8; e.data = '0; e.data[15:0] = 16'h1234;
    exp_q.push_back(e);
    send_cmd(5'd8, 4'd1, hs);
    send_beat(BW'(16'h1234), hs);
    wait_idle();
    chk("midrst_write_count", 64'(wr_log.size()), 64'd1);

    // Two consecutive LMUL=1 groups: spacing of write pulses
    wr_log.delete();
    e.addr = 5'd1; e.data = '0; e.data[7:0] = 8'h11;
    exp_q.push_back(e);
    e.addr = 5'd2; e.data = '0; e.data[7:0] = 8'h22;
    exp_q.push_back(e);
    send_cmd(5'd1, 4'd1, hs);
    send_beat(BW'(8'h11), hs);
    send_cmd(5'd2, 4'd1, hs);
    send_beat(BW'(8'h22), hs);
    wait_idle();
    chk("gap_write_count", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() == 2) chk("wr_gap", 64'(wr_log[1] - wr_log[0]), 64'(EXP_GAP));

    chk("scoreboard_drained", 64'(exp_q.size() + err_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
